// File: rtl/burst_gen_pkg.sv
// Shared definitions for the burst generator: FSM encodings and default widths.
// Imported by the RTL and by the bench so both agree on state values.
package burst_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    localparam int DEF_CW = 16;
    localparam int DEF_NW = 8;

endpackage

// File: rtl/burst_gen_if.sv
// Bundle of the burst generator's control inputs, status outputs and debug view.
// tick is a one-cycle strobe with no back-pressure; ticks that land while busy are dropped and reported on overrun.
interface burst_gen_if
    import burst_gen_pkg::*;
#(
    parameter int CW = DEF_CW,
    parameter int NW = DEF_NW
);
    logic          en;
    logic          tick;
    logic [CW-1:0] hi_len;
    logic [CW-1:0] lo_len;
    logic [NW-1:0] num;
    logic          pulse_out;
    logic          busy;
    logic          done;
    logic          overrun;
    state_t        state;
    logic [CW-1:0] phase;

    modport master (
        output en, tick, hi_len, lo_len, num,
        input  pulse_out, busy, done, overrun, state, phase
    );

    modport slave (
        input  en, tick, hi_len, lo_len, num,
        output pulse_out, busy, done, overrun, state, phase
    );

endinterface

// File: rtl/phase_cnt.sv
// Loadable down-counter timing one HIGH or LOW phase; it holds at zero until reloaded.
module phase_cnt #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] value,
    output logic          zero
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/burst_gen.sv
// Burst generator: on an accepted tick emits num pulses of hi_len cycles separated by lo_len-cycle gaps.
// Lengths of zero behave as one; all outputs come straight from flops.
module burst_gen
    import burst_gen_pkg::*;
#(
    parameter int CW = DEF_CW,
    parameter int NW = DEF_NW
) (
    input  logic       clk,
    input  logic       rst,
    burst_gen_if.slave bus
);

    state_t        state_q, state_d;
    logic [CW-1:0] hi_q, hi_d;
    logic [CW-1:0] lo_q, lo_d;
    logic [NW-1:0] rem_q, rem_d;
    logic          pulse_q, pulse_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;

    logic          cnt_load;
    logic          cnt_dec;
    logic [CW-1:0] cnt_val;
    logic [CW-1:0] cnt_value;
    logic          cnt_zero;

    // The counter runs down to zero inclusive, so a phase of N cycles loads N-1.
    function automatic logic [CW-1:0] len_m1(input logic [CW-1:0] len);
        return (len == '0) ? '0 : len - CW'(1);
    endfunction

    phase_cnt #(.CW(CW)) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .value    (cnt_value),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        rem_d    = rem_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        done_d   = 1'b0;
        ovr_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.tick && bus.en && (bus.num != '0)) begin
                    hi_d     = bus.hi_len;
                    lo_d     = bus.lo_len;
                    rem_d    = bus.num;
                    cnt_load = 1'b1;
                    cnt_val  = len_m1(bus.hi_len);
                    state_d  = ST_HIGH;
                end
            end
            ST_HIGH: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    rem_d = rem_q - NW'(1);
                    if (rem_q == NW'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_load = 1'b1;
                        cnt_val  = len_m1(lo_q);
                        state_d  = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    cnt_load = 1'b1;
                    cnt_val  = len_m1(hi_q);
                    state_d  = ST_HIGH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.tick && bus.en && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end

        // Disable wins over everything: abort silently, no done for a partial burst.
        if (!bus.en) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end

        pulse_d = (state_d == ST_HIGH);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.overrun   = ovr_q;
    assign bus.state     = state_q;
    assign bus.phase     = cnt_value;

endmodule

// File: tb/tb_burst_gen.sv
// Directed bench for burst_gen: a per-cycle vector table plus hand-written reset,
// long-burst and full-scale sequences.
module tb_burst_gen;
    import burst_gen_pkg::*;

    localparam int CW = 16;
    localparam int NW = 8;

    logic clk;
    logic rst;

    burst_gen_if #(.CW(CW), .NW(NW)) bus ();

    burst_gen #(.CW(CW), .NW(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int            sc;
        int            cyc;
        logic          en;
        logic          tick;
        logic [CW-1:0] hi;
        logic [CW-1:0] lo;
        logic [NW-1:0] num;
        logic          p;
        logic          b;
        logic          d;
        logic          o;
    } vec_t;

    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic p, input logic b,
                              input logic d, input logic o);
        state_t exp_st;
        exp_st = p ? ST_HIGH : (b ? ST_LOW : ST_IDLE);
        check_bit({tag, "_pulse"},   bus.pulse_out, p);
        check_bit({tag, "_busy"},    bus.busy,      b);
        check_bit({tag, "_done"},    bus.done,      d);
        check_bit({tag, "_overrun"}, bus.overrun,   o);
        check_int({tag, "_state"},   int'(bus.state), int'(exp_st));
    endtask

    task automatic drive(input logic en, input logic tick, input logic [CW-1:0] hi,
                         input logic [CW-1:0] lo, input logic [NW-1:0] num);
        bus.en     = en;
        bus.tick   = tick;
        bus.hi_len = hi;
        bus.lo_len = lo;
        bus.num    = num;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int sc, input int cyc, input logic en, input logic tick,
                       input logic [CW-1:0] hi, input logic [CW-1:0] lo,
                       input logic [NW-1:0] num, input logic p, input logic b,
                       input logic d, input logic o);
        vec_t v;
        v.sc = sc; v.cyc = cyc; v.en = en; v.tick = tick;
        v.hi = hi; v.lo = lo; v.num = num;
        v.p = p; v.b = b; v.d = d; v.o = o;
        vecs.push_back(v);
    endtask

    function automatic logic in_rng(input int n, input int lo, input int hi);
        return (n >= lo) && (n <= hi);
    endfunction

    // hi=3, lo=2, num=3 started by a tick in cycle 0
    function automatic logic a_pulse(input int n);
        return in_rng(n, 1, 3) || in_rng(n, 6, 8) || in_rng(n, 11, 13);
    endfunction

    initial begin
        int n;
        int cnt;
        int done_cyc;

        // Vector i: inputs held during cycle i, outputs expected in cycle i+1.
        for (int c = 0; c <= 15; c++) begin
            n = c + 1;
            add(0, c, 1'b1, c == 0, 16'd3, 16'd2, 8'd3,
                a_pulse(n), in_rng(n, 1, 13), n == 14, 1'b0);
        end
        // Same burst, inputs changed after latching and a tick landing mid-burst.
        for (int c = 0; c <= 15; c++) begin
            n = c + 1;
            add(1, c, 1'b1, (c == 0) || (c == 5), (c >= 2) ? 16'd7 : 16'd3, 16'd2,
                (c >= 2) ? 8'd5 : 8'd3,
                a_pulse(n), in_rng(n, 1, 13), n == 14, n == 6);
        end
        for (int c = 0; c <= 6; c++) begin
            n = c + 1;
            add(2, c, 1'b1, c == 0, 16'd0, 16'd0, 8'd2,
                (n == 1) || (n == 3), in_rng(n, 1, 3), n == 4, 1'b0);
        end
        for (int c = 0; c <= 16; c++) begin
            n = c + 1;
            add(3, c, c != 4, c == 0, 16'd3, 16'd2, 8'd3,
                in_rng(n, 1, 3), in_rng(n, 1, 4), 1'b0, 1'b0);
        end
        for (int c = 0; c <= 13; c++) begin
            n = c + 1;
            add(4, c, c != 11, (c == 0) || (c == 4) || (c == 9) || (c == 11),
                16'd1, 16'd1, (c == 9) ? 8'd0 : 8'd2,
                (n == 1) || (n == 3) || (n == 5) || (n == 7),
                in_rng(n, 1, 3) || in_rng(n, 5, 7), (n == 4) || (n == 8), 1'b0);
        end

        rst = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0);
        #2 rst = 1'b1;
        #1 check_outs("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) step();
        check_outs("reset_clocked", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].tick, vecs[i].hi, vecs[i].lo, vecs[i].num);
            step();
            check_outs($sformatf("sc%0d_c%0d", vecs[i].sc, vecs[i].cyc + 1),
                       vecs[i].p, vecs[i].b, vecs[i].d, vecs[i].o);
        end

        // Reset asserted between clock edges while HIGH.
        drive(1'b1, 1'b1, 16'd3, 16'd2, 8'd3);
        step();
        drive(1'b1, 1'b0, 16'd3, 16'd2, 8'd3);
        step();
        check_outs("rst_pre", 1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check_outs("rst_mid_high", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        check_outs("rst_release", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c <= 15; c++) begin
            n = c + 1;
            drive(1'b1, c == 0, 16'd3, 16'd2, 8'd3);
            step();
            check_outs($sformatf("post_rst_c%0d", n),
                       a_pulse(n), in_rng(n, 1, 13), n == 14, 1'b0);
        end

        // Full-scale pulse count with unit lengths: 255 pulses, done at cycle 510.
        drive(1'b1, 1'b1, 16'd0, 16'd0, 8'd255);
        step();
        cnt = 0;
        done_cyc = -1;
        for (int k = 1; k <= 1000; k++) begin
            if (bus.pulse_out === 1'b1) cnt++;
            if (bus.done === 1'b1) begin
                done_cyc = k;
                break;
            end
            if (k == 1) drive(1'b1, 1'b0, 16'd0, 16'd0, 8'd255);
            step();
        end
        check_int("num255_done_cycle", done_cyc, 510);
        check_int("num255_pulses", cnt, 255);

        // Full-scale high length: still high deep into the phase, then aborted.
        drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 8'd1);
        step();
        drive(1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 8'd1);
        repeat (199) step();
        check_outs("hi_max_c200", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 8'd1);
        step();
        check_outs("hi_max_abort", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/burst_gen.md
BURST_GEN -- requirements
Module: burst_gen

Interface
REQ-001 SHALL have parameter CW, default 16: width of the high-time and low-time counters and length inputs.
REQ-002 SHALL have parameter NW, default 8: width of the pulse-count input and remaining-pulse counter.
REQ-003 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  block enable; low aborts any burst and blocks starts.
REQ-006 SHALL have port tick  input  1  single-cycle trigger, driven by the period timer's out.
REQ-007 SHALL have port hi_len  input  CW  high-phase length in clk cycles.
REQ-008 SHALL have port lo_len  input  CW  low-phase (gap) length in clk cycles.
REQ-009 SHALL have port num  input  NW  pulses per burst.
REQ-010 SHALL have port pulse_out  output  1  registered burst output.
REQ-011 SHALL have port busy  output  1  registered; high while in HIGH or LOW state.
REQ-012 SHALL have port done  output  1  registered single-cycle end-of-burst flag.
REQ-013 SHALL have port overrun  output  1  registered single-cycle flag: tick arrived while busy.

Function
REQ-014 SHALL implement FSM states IDLE, HIGH, LOW; pulse_out = 1 exactly in HIGH, busy = 1 in HIGH or LOW.
REQ-015 SHALL, on tick=1 with en=1, num!=0 in IDLE, latch hi_len, lo_len, num into internal registers and enter HIGH on the next edge (pulse_out rises 1 cycle after tick).
REQ-016 SHALL ignore hi_len/lo_len/num changes after latching until the next accepted start.
REQ-017 SHALL hold HIGH for max(hi_len,1) cycles and LOW for max(lo_len,1) cycles; length 0 is treated as 1.
REQ-018 SHALL, at the end of HIGH, decrement the remaining count; if it becomes 0 go to IDLE, else go to LOW; at the end of LOW go to HIGH.
REQ-019 SHALL assert done for exactly the first IDLE cycle after the final HIGH cycle of a complete burst.
REQ-020 SHALL accept a start tick arriving in the same cycle done is high (back-to-back bursts, one IDLE cycle between them).
REQ-021 SHALL, on tick=1 while busy, not restart or extend the burst and assert overrun for the following cycle.
REQ-022 SHALL, on tick with num=0 or en=0 in IDLE, stay IDLE with no done and no overrun.
REQ-023 SHALL, when en drops while busy, enter IDLE on the next edge with pulse_out=0, busy=0, and no done.
REQ-024 SHALL support full-scale values (hi_len, lo_len = 2^CW-1; num = 2^NW-1) without counter wrap-around errors.

Reset
REQ-025 SHALL, while rst=1, force state IDLE, pulse_out=0, busy=0, done=0, overrun=0, and all internal counters and latched registers to 0, regardless of clk.
REQ-026 SHALL, on rst asserted mid-burst, abandon the burst immediately; the first tick after rst release starts a fresh burst.

Structure
REQ-027 SHALL take its FSM state encodings from a shared package/include (burst_gen_pkg), also used by the bench.
REQ-028 SHALL implement phase timing with one sub-module, phase_cnt: a CW-bit loadable down-counter with load, value and zero outputs, shared by HIGH and LOW.

Verification
REQ-029 SHALL cover: hi_len=3, lo_len=2, num=3, tick at cycle 0 -> pulse_out high cycles 1-3, 6-8, 11-13; done at cycle 14.
REQ-030 SHALL cover: hi_len=0, lo_len=0, num=2 -> pulse_out high cycles 1 and 3, low at cycle 2; done at cycle 4.
REQ-031 SHALL cover: tick at cycle 5 during a burst -> overrun=1 at cycle 6; pulse timing unchanged.
REQ-032 SHALL cover: en dropped at cycle 4 in a burst -> pulse_out=0, busy=0 at cycle 5; done never asserts.
REQ-033 SHALL cover: second tick coincident with done -> next burst's pulse_out rises the following cycle; plus num=0 tick -> no activity.
REQ-034 SHALL cover: rst pulsed mid-HIGH -> all outputs 0 asynchronously; next tick after release starts a normal burst.
